btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 18 +
 rtl/btn_conditioner_chan.sv | 128 ++++++++++++
 rtl/btn_conditioner.sv | 36 +++
 tb/tb_btn_conditioner.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the button conditioner.
package btn_pkg;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT  = 800000;
   localparam int unsigned LONGPRESS_CYCLES_DEFAULT = 80000000;

   typedef enum logic [1:0] {
      StReleased,
      StConfirmPress,
      StPressed,
      StConfirmRelease
   } btn_state_e;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_conditioner_chan.sv
// One button channel: 2-flop synchronizer, debounce FSM and a saturating counter.
// Long-press hold counting exists only when BTN_CONDITIONER_LONGPRESS_EN is defined.
module btn_conditioner_chan
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned LONGPRESS_CYCLES = LONGPRESS_CYCLES_DEFAULT
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o
);

   localparam int unsigned CntW = $clog2(max_u(DEBOUNCE_CYCLES, LONGPRESS_CYCLES));
   // Confirm entry clears the counter, so the last confirm cycle sees DEBOUNCE_CYCLES-2.
   localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 2);

   btn_state_e      state_q;
   logic [1:0]      sync_q;
   logic [CntW-1:0] cnt_q;
   logic [CntW-1:0] cnt_inc;
   logic            sync_in;
   logic            level_q;
   logic            press_q;
   logic            release_q;

`ifdef BTN_CONDITIONER_LONGPRESS_EN
   localparam logic [CntW-1:0] LongLast = CntW'(LONGPRESS_CYCLES - 1);
   logic long_q;
   logic long_done_q;
`endif

   assign sync_in = sync_q[1];
   assign cnt_inc = (cnt_q == {CntW{1'b1}}) ? cnt_q : cnt_q + CntW'(1);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync_q    <= 2'b00;
         state_q   <= StReleased;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef BTN_CONDITIONER_LONGPRESS_EN
         long_q      <= 1'b0;
         long_done_q <= 1'b0;
`endif
      end else begin
         sync_q    <= {sync_q[0], raw_i};
         press_q   <= 1'b0;
         release_q <= 1'b0;
`ifdef BTN_CONDITIONER_LONGPRESS_EN
         long_q    <= 1'b0;
`endif
         unique case (state_q)
            StReleased: begin
               if (sync_in) begin
                  state_q <= StConfirmPress;
                  cnt_q   <= '0;
               end
            end
            StConfirmPress: begin
               if (!sync_in) begin
                  state_q <= StReleased;
                  cnt_q   <= '0;
               end else if (cnt_q == DebLast) begin
                  state_q <= StPressed;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
`ifdef BTN_CONDITIONER_LONGPRESS_EN
                  long_done_q <= 1'b0;
`endif
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            StPressed: begin
               if (!sync_in) begin
                  state_q <= StConfirmRelease;
                  cnt_q   <= '0;
               end
`ifdef BTN_CONDITIONER_LONGPRESS_EN
               else begin
                  cnt_q <= cnt_inc;
                  if (cnt_q == LongLast && !long_done_q) begin
                     long_q      <= 1'b1;
                     long_done_q <= 1'b1;
                  end
               end
`endif
            end
            StConfirmRelease: begin
               if (sync_in) begin
                  state_q <= StPressed;
                  cnt_q   <= '0;
               end else if (cnt_q == DebLast) begin
                  state_q   <= StReleased;
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: begin
               state_q <= StReleased;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;

`ifdef BTN_CONDITIONER_LONGPRESS_EN
   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/btn_conditioner.sv
// NBTN independent debounced button channels with press/release/long-press pulses.
// Long-press detection is enabled by defining BTN_CONDITIONER_LONGPRESS_EN.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned NBTN             = 4,
   parameter int unsigned DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned LONGPRESS_CYCLES = LONGPRESS_CYCLES_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_level,
   output logic [NBTN-1:0] btn_press,
   output logic [NBTN-1:0] btn_release,
   output logic [NBTN-1:0] btn_long
);

   generate
      for (genvar i = 0; i < NBTN; i++) begin : g_chan
         btn_conditioner_chan #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONGPRESS_CYCLES (LONGPRESS_CYCLES)
         ) u_chan (
            .clk_i     (clk),
            .reset_i   (reset),
            .raw_i     (btn_raw[i]),
            .level_o   (btn_level[i]),
            .press_o   (btn_press[i]),
            .release_o (btn_release[i]),
            .long_o    (btn_long[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed scenarios plus randomized button traffic checked against a run-length reference model.
module tb_btn_conditioner;

   localparam int NBTN = 4;
   localparam int DEB  = 4;
   localparam int LONG = 12;

`ifdef BTN_CONDITIONER_LONGPRESS_EN
   localparam bit LongEn     = 1'b1;
   localparam int ExpLongCnt = 1;
   localparam int ExpLongAt  = LONG;
`else
   localparam bit LongEn     = 1'b0;
   localparam int ExpLongCnt = 0;
   localparam int ExpLongAt  = 0;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [NBTN-1:0] btn_raw = '0;
   logic [NBTN-1:0] btn_level;
   logic [NBTN-1:0] btn_press;
   logic [NBTN-1:0] btn_release;
   logic [NBTN-1:0] btn_long;

   always #5 clk = ~clk;

   btn_conditioner #(
      .NBTN             (NBTN),
      .DEBOUNCE_CYCLES  (DEB),
      .LONGPRESS_CYCLES (LONG)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .btn_long    (btn_long)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: the debounced level flips after DEB consecutive synchronized
   // samples that disagree with it; hold time is a streak of agreeing samples.
   logic [NBTN-1:0] m_s1 = '0, m_s2 = '0, m_prev = '0, m_fired = '0;
   int              m_run[NBTN];
   int              m_hold[NBTN];
   logic [NBTN-1:0] e_level = '0, e_press = '0, e_release = '0, e_long = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge();
      logic obs;
      for (int c = 0; c < NBTN; c++) begin
         e_press[c]   = 1'b0;
         e_release[c] = 1'b0;
         e_long[c]    = 1'b0;
         if (reset) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_prev[c] = 1'b0; m_fired[c] = 1'b0;
            e_level[c] = 1'b0; m_run[c] = 0; m_hold[c] = 0;
         end else begin
            obs     = m_s2[c];
            m_s2[c] = m_s1[c];
            m_s1[c] = btn_raw[c];
            if (obs != e_level[c]) begin
               m_run[c]++;
               if (m_run[c] == DEB) begin
                  e_level[c] = obs;
                  m_run[c]   = 0;
                  if (obs) begin
                     e_press[c] = 1'b1;
                     m_hold[c]  = 0;
                     m_fired[c] = 1'b0;
                  end else begin
                     e_release[c] = 1'b1;
                  end
               end
            end else begin
               m_run[c] = 0;
               if (e_level[c]) begin
                  m_hold[c] = m_prev[c] ? m_hold[c] + 1 : 0;
                  if (LongEn && m_hold[c] == LONG && !m_fired[c]) begin
                     e_long[c]  = 1'b1;
                     m_fired[c] = 1'b1;
                  end
               end
            end
            m_prev[c] = obs;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      chk("model_level",   btn_level,   e_level);
      chk("model_press",   btn_press,   e_press);
      chk("model_release", btn_release, e_release);
      chk("model_long",    btn_long,    e_long);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) tick();
   endtask

   task automatic wait_press(input int ch, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!btn_press[ch] && n < 20);
   endtask

   task automatic wait_release(input int ch, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!btn_release[ch] && n < 20);
   endtask

   initial begin
      int n, cnt, nlong, at_long, rst_left;
      int run_left[NBTN];
      logic [4:0] pat;

      // Reset state
      idle(3);
      chk("reset_outputs", {btn_level, btn_press, btn_release, btn_long}, 0);
      reset = 1'b0;
      idle(4);

      // Clean press and release on channel 0
      btn_raw[0] = 1'b1;
      wait_press(0, n);
      chk("clean_press_latency", n, 6);
      chk("clean_level", btn_level[0], 1);
      chk("clean_no_release", btn_release[0], 0);
      tick();
      chk("clean_press_width", btn_press[0], 0);
      btn_raw[0] = 1'b0;
      wait_release(0, n);
      chk("clean_release_latency", n, 6);
      idle(4);

      // Glitch on channel 1: three high cycles are rejected
      cnt = 0;
      btn_raw[1] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         if (i == 3) btn_raw[1] = 1'b0;
         tick();
         cnt += int'(btn_level[1]) + int'(btn_press[1]) + int'(btn_release[1]);
      end
      chk("glitch_activity", cnt, 0);

      // Bounce on channel 2 then hold
      pat = 5'b10101;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         btn_raw[2] = pat[i];
         tick();
         cnt += int'(btn_press[2]);
      end
      btn_raw[2] = pat[4];
      wait_press(2, n);
      chk("bounce_latency", n, 6);
      cnt += int'(btn_press[2]);
      for (int i = 0; i < 10; i++) begin
         tick();
         cnt += int'(btn_press[2]);
      end
      chk("bounce_press_count", cnt, 1);
      btn_raw[2] = 1'b0;
      idle(10);

      // Reset two cycles into confirmation with channel 0 held
      btn_raw[0] = 1'b1;
      idle(4);
      reset = 1'b1;
      idle(2);
      chk("midreset_outputs", {btn_level, btn_press, btn_release, btn_long}, 0);
      reset = 1'b0;
      wait_press(0, n);
      chk("midreset_press_latency", n, 6);
      btn_raw[0] = 1'b0;
      idle(10);

      // Long press on channel 3
      btn_raw[3] = 1'b1;
      wait_press(3, n);
      chk("long_press_latency", n, 6);
      nlong = 0;
      at_long = 0;
      for (int i = 1; i <= 32; i++) begin
         tick();
         if (btn_long[3]) begin
            nlong++;
            if (at_long == 0) at_long = i;
         end
      end
      chk("long_count", nlong, ExpLongCnt);
      chk("long_offset", at_long, ExpLongAt);
      btn_raw[3] = 1'b0;
      idle(10);

      // All four pressed together
      btn_raw = 4'hF;
      n = 0;
      do begin
         tick();
         n++;
      end while (btn_press == 4'h0 && n < 20);
      chk("simul_press", btn_press, 4'hF);
      chk("simul_latency", n, 6);
      tick();
      chk("simul_press_width", btn_press, 4'h0);
      btn_raw = 4'h0;
      idle(10);

      // Randomized traffic with occasional resets
      rst_left = 0;
      for (int c = 0; c < NBTN; c++) run_left[c] = $urandom_range(1, 6);
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (rst_left == 0 && $urandom_range(0, 299) == 0) rst_left = $urandom_range(1, 3);
         reset = (rst_left > 0);
         if (rst_left > 0) rst_left--;
         for (int c = 0; c < NBTN; c++) begin
            if (run_left[c] == 0) begin
               btn_raw[c]  = ~btn_raw[c];
               run_left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                          : $urandom_range(1, 6);
            end
            run_left[c]--;
         end
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
